// File: rtl/pingpong_ctrl_if.sv
// Signal bundle between the ping-pong controller and its surroundings:
// the upstream handshake, the two external bank FIFOs, the downstream
// stream and the bank indicators. The controller connects to the slave
// modport. The master modport is the view of the logic around it.
interface pingpong_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en_a;
  logic                  wr_en_b;
  logic                  fifo_a_full;
  logic                  fifo_b_full;
  logic                  fifo_a_empty;
  logic                  fifo_b_empty;
  logic [DATA_WIDTH-1:0] fifo_a_dout;
  logic [DATA_WIDTH-1:0] fifo_b_dout;
  logic                  rd_en_a;
  logic                  rd_en_b;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wr_bank;
  logic                  rd_bank;

  modport slave (
    input  in_valid,
    output in_ready,
    output wr_en_a,
    output wr_en_b,
    input  fifo_a_full,
    input  fifo_b_full,
    input  fifo_a_empty,
    input  fifo_b_empty,
    input  fifo_a_dout,
    input  fifo_b_dout,
    output rd_en_a,
    output rd_en_b,
    output out_data,
    output out_valid,
    input  out_ready,
    output wr_bank,
    output rd_bank
  );

  modport master (
    output in_valid,
    input  in_ready,
    input  wr_en_a,
    input  wr_en_b,
    output fifo_a_full,
    output fifo_b_full,
    output fifo_a_empty,
    output fifo_b_empty,
    output fifo_a_dout,
    output fifo_b_dout,
    input  rd_en_a,
    input  rd_en_b,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  wr_bank,
    input  rd_bank
  );
endinterface

// File: rtl/pingpong_ctrl.sv
// Ping-pong controller for two external first-word-fall-through bank FIFOs.
// The write side fills bursts of BURST_LEN words alternately into bank A and
// bank B. A completed burst marks its bank pending, and the read side then
// drains exactly that burst to the downstream stream. A bank with a pending
// burst accepts no writes until the read side has drained it.
module pingpong_ctrl #(
  parameter int DEPTH_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pingpong_ctrl_if.slave   bus
);

  localparam logic [DEPTH_SIZE:0] CNT_LAST = (DEPTH_SIZE + 1)'(BURST_LEN - 1);
  localparam logic [DEPTH_SIZE:0] CNT_ONE  = (DEPTH_SIZE + 1)'(1);

  typedef enum logic { W_A = 1'b0, W_B = 1'b1 } wstate_t;
  typedef enum logic { R_IDLE = 1'b0, R_ACT = 1'b1 } rstate_t;

  wstate_t               wstate_reg, wstate_next;
  rstate_t               rstate_reg, rstate_next;
  logic [DEPTH_SIZE:0]   wcnt_reg, wcnt_next;
  logic [DEPTH_SIZE:0]   rcnt_reg, rcnt_next;
  logic [1:0]            pending_reg, pending_next;
  logic [1:0]            pend_set, pend_clr;
  logic                  rd_bank_reg, rd_bank_next;

  logic                  wr_bank;
  logic                  wr_full;
  logic                  in_ready_int;
  logic                  wr_fire;
  logic                  wr_last;
  logic                  rd_empty;
  logic                  out_valid_int;
  logic                  rd_fire;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] mux_data;

  // The write bank is the write FSM state itself.
  assign wr_bank = (wstate_reg == W_B);

  // Write FSM: accept words into the current bank and switch banks on the last word of a burst.
  always_comb begin
    wstate_next  = wstate_reg;
    wcnt_next    = wcnt_reg;
    wr_last      = 1'b0;
    wr_full      = wr_bank ? bus.fifo_b_full : bus.fifo_a_full;
    in_ready_int = ~wr_full & ~pending_reg[wr_bank];
    wr_fire      = bus.in_valid & in_ready_int;
    if (wr_fire) begin
      if (wcnt_reg == CNT_LAST) begin
        wr_last     = 1'b1;
        wcnt_next   = '0;
        wstate_next = (wstate_reg == W_A) ? W_B : W_A;
      end else begin
        wcnt_next = wcnt_reg + CNT_ONE;
      end
    end
  end

  // Per-bank pending flags: a set and a clear can hit different banks on the same edge.
  // The same bank never sees both because writes into a pending bank are blocked.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      assign pend_set[gi]     = wr_last & (wr_bank == 1'(gi));
      assign pend_clr[gi]     = rd_last & (rd_bank_reg == 1'(gi));
      assign pending_next[gi] = (pending_reg[gi] | pend_set[gi]) & ~pend_clr[gi];
    end
  endgenerate

  // Read FSM: wait for a complete burst in rd_bank, then stream exactly BURST_LEN words out of it.
  always_comb begin
    rstate_next   = rstate_reg;
    rcnt_next     = rcnt_reg;
    rd_bank_next  = rd_bank_reg;
    out_valid_int = 1'b0;
    rd_fire       = 1'b0;
    rd_last       = 1'b0;
    rd_empty      = rd_bank_reg ? bus.fifo_b_empty : bus.fifo_a_empty;
    mux_data      = rd_bank_reg ? bus.fifo_b_dout : bus.fifo_a_dout;
    case (rstate_reg)
      R_IDLE: begin
        // A burst that completes on this edge starts the read at once.
        if (pending_reg[rd_bank_reg] | pend_set[rd_bank_reg]) begin
          rstate_next = R_ACT;
        end
      end
      R_ACT: begin
        out_valid_int = ~rd_empty;
        rd_fire       = out_valid_int & bus.out_ready;
        if (rd_fire) begin
          if (rcnt_reg == CNT_LAST) begin
            rd_last      = 1'b1;
            rcnt_next    = '0;
            rd_bank_next = ~rd_bank_reg;
            rstate_next  = R_IDLE;
          end else begin
            rcnt_next = rcnt_reg + CNT_ONE;
          end
        end
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  // State registers for both sides. Reset discards any partial burst at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_reg  <= W_A;
      rstate_reg  <= R_IDLE;
      wcnt_reg    <= '0;
      rcnt_reg    <= '0;
      pending_reg <= 2'b00;
      rd_bank_reg <= 1'b0;
    end else begin
      wstate_reg  <= wstate_next;
      rstate_reg  <= rstate_next;
      wcnt_reg    <= wcnt_next;
      rcnt_reg    <= rcnt_next;
      pending_reg <= pending_next;
      rd_bank_reg <= rd_bank_next;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.wr_en_a   = wr_fire & ~wr_bank;
  assign bus.wr_en_b   = wr_fire & wr_bank;
  assign bus.rd_en_a   = rd_fire & ~rd_bank_reg;
  assign bus.rd_en_b   = rd_fire & rd_bank_reg;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = mux_data;
  assign bus.wr_bank   = wr_bank;
  assign bus.rd_bank   = rd_bank_reg;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with two behavioural FWFT bank FIFOs.
// Upstream data is a running counter, so the expected output order follows
// directly from the number of words written.
module tb_pingpong_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;

  int checks;
  int errors;

  pingpong_ctrl_if #(.DATA_WIDTH(8)) bus ();

  pingpong_ctrl #(
    .DEPTH_SIZE(4),
    .DATA_WIDTH(8),
    .BURST_LEN (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural bank FIFOs (index 0 = A, 1 = B), reset by the same rst_n.
  logic [7:0] mem [2][16];
  logic [3:0] wp [2];
  logic [3:0] rp [2];
  logic [4:0] cnt [2];
  logic [1:0] fw, fr;

  assign fw = {bus.wr_en_b, bus.wr_en_a};
  assign fr = {bus.rd_en_b, bus.rd_en_a};

  // FIFO storage and pointer update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        wp[b]  <= 4'd0;
        rp[b]  <= 4'd0;
        cnt[b] <= 5'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (fw[b]) begin
          mem[b][wp[b]] <= in_data;
          wp[b]         <= wp[b] + 4'd1;
        end
        if (fr[b]) rp[b] <= rp[b] + 4'd1;
        cnt[b] <= cnt[b] + 5'(fw[b]) - 5'(fr[b]);
      end
    end
  end

  assign bus.fifo_a_full  = (cnt[0] == 5'd16);
  assign bus.fifo_b_full  = (cnt[1] == 5'd16);
  assign bus.fifo_a_empty = (cnt[0] == 5'd0);
  assign bus.fifo_b_empty = (cnt[1] == 5'd0);
  assign bus.fifo_a_dout  = mem[0][rp[0]];
  assign bus.fifo_b_dout  = mem[1][rp[1]];

  // One comparison: count it, report it.
  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Samples of the strobes during the cycle just stepped.
  logic       s_wr_a, s_wr_b, s_rd_a, s_rd_b, s_ov;
  logic [7:0] s_od;

  // Called at posedge+1 with inputs already driven: sample, cross one edge,
  // and advance the upstream word if it was accepted.
  task automatic step();
    #1;
    s_wr_a = bus.wr_en_a;
    s_wr_b = bus.wr_en_b;
    s_rd_a = bus.rd_en_a;
    s_rd_b = bus.rd_en_b;
    s_ov   = bus.out_valid;
    s_od   = bus.out_data;
    @(posedge clk);
    #1;
    if (s_wr_a | s_wr_b) in_data = in_data + 8'd1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    in_data      = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int wa, wb, reads, exp_rd, first_wr, both;
  logic ever_ov, ever_rd;

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    in_data = 8'd0;

    // Reset state while rst_n is held low.
    #3;
    check_val("rst_wr_bank", int'(bus.wr_bank), 0);
    check_val("rst_rd_bank", int'(bus.rd_bank), 0);
    check_val("rst_out_valid", int'(bus.out_valid), 0);
    check_val("rst_wr_en", int'(bus.wr_en_a | bus.wr_en_b), 0);
    check_val("rst_rd_en", int'(bus.rd_en_a | bus.rd_en_b), 0);
    check_val("rst_in_ready", int'(bus.in_ready), 1);

    // One full burst into A with the consumer stalled.
    do_reset();
    wa = 0; wb = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_wr_a) wa++;
      if (s_wr_b) wb++;
    end
    bus.in_valid = 1'b0;
    #1;
    check_val("b1_wr_a_cycles", wa, 16);
    check_val("b1_wr_b_cycles", wb, 0);
    check_val("b1_wr_bank", int'(bus.wr_bank), 1);
    check_val("b1_out_valid", int'(bus.out_valid), 1);
    check_val("b1_out_data", int'(bus.out_data), 0);
    check_val("b1_rd_bank", int'(bus.rd_bank), 0);

    // Keep pushing: B fills, then A is still pending so input stalls.
    wa = 0; wb = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_wr_a) wa++;
      if (s_wr_b) wb++;
    end
    check_val("b2_wr_b_cycles", wb, 16);
    check_val("b2_wr_a_blocked", wa, 0);
    check_val("b2_in_ready", int'(bus.in_ready), 0);
    check_val("b2_wr_bank", int'(bus.wr_bank), 0);
    check_val("b2_out_data", int'(bus.out_data), 0);

    // Drain both bursts with out_ready toggling; third burst enters A once it drains.
    reads = 0; exp_rd = 0; first_wr = -1; wa = 0;
    for (int cyc = 0; cyc < 200 && reads < 32; cyc++) begin
      bus.out_ready = ((cyc % 2) == 0);
      step();
      if (s_rd_a | s_rd_b) begin
        check_val("rd_data", int'(s_od), exp_rd);
        check_val("rd_from_b", int'(s_rd_b), (exp_rd >= 16) ? 1 : 0);
        exp_rd++;
        reads++;
      end
      if (s_wr_a) begin
        if (first_wr < 0) first_wr = reads;
        wa++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_val("drain_reads", reads, 32);
    check_val("third_burst_start", first_wr, 16);
    check_val("third_burst_len", wa, 16);
    check_val("drain_wr_bank", int'(bus.wr_bank), 1);
    check_val("drain_idle_valid", int'(bus.out_valid), 0);
    check_val("drain_rd_bank", int'(bus.rd_bank), 0);
    step();
    check_val("third_valid", int'(bus.out_valid), 1);
    check_val("third_data", int'(bus.out_data), 32);

    // Partial burst of 10 words is never offered downstream.
    do_reset();
    wa = 0; ever_ov = 1'b0; ever_rd = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) bus.in_valid = 1'b0;
      step();
      if (s_wr_a) wa++;
      ever_ov = ever_ov | s_ov;
      ever_rd = ever_rd | s_rd_a | s_rd_b;
    end
    check_val("part_wr_a", wa, 10);
    check_val("part_out_valid", int'(ever_ov), 0);
    check_val("part_rd_en", int'(ever_rd), 0);
    check_val("part_wr_bank", int'(bus.wr_bank), 0);

    // Reset in the middle of burst B (wcnt = 7) takes effect without a clock edge.
    do_reset();
    wb = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 23; i++) begin
      step();
      if (s_wr_b) wb++;
    end
    bus.in_valid = 1'b0;
    check_val("mid_wr_b", wb, 7);
    check_val("mid_pre_wr_bank", int'(bus.wr_bank), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_wr_bank", int'(bus.wr_bank), 0);
    check_val("async_out_valid", int'(bus.out_valid), 0);
    check_val("async_rd_bank", int'(bus.rd_bank), 0);
    check_val("async_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_data = 8'd100;
    wa = 0; wb = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_wr_a) wa++;
      if (s_wr_b) wb++;
    end
    bus.in_valid = 1'b0;
    #1;
    check_val("post_rst_wr_a", wa, 16);
    check_val("post_rst_wr_b", wb, 0);
    check_val("post_rst_wr_bank", int'(bus.wr_bank), 1);
    check_val("post_rst_data", int'(bus.out_data), 100);

    // Last read of A and last write of B land on the same edge.
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.out_ready = 1'b1;
    both = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_wr_b && s_rd_a) both++;
      if (i == 15) check_val("co_last_rd_data", int'(s_od), 15);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_val("co_both_cycles", both, 16);
    check_val("co_idle_valid", int'(bus.out_valid), 0);
    check_val("co_rd_bank", int'(bus.rd_bank), 1);
    check_val("co_wr_bank", int'(bus.wr_bank), 0);
    check_val("co_in_ready", int'(bus.in_ready), 1);
    step();
    check_val("co_act_valid", int'(bus.out_valid), 1);
    check_val("co_act_data", int'(bus.out_data), 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
